// File: rtl/daq_buffer_scheduler.sv
// daq_buffer_scheduler
// Owns the circular pool of readout buffers shared by the front-end writer
// and the DMA bundler. It grants buffers to the writer and keeps a table of
// readout lengths. It also tracks the committed readouts and the oldest one,
// and retires buffers when the bundler is done with them.
module daq_buffer_scheduler #(
    parameter int NBUF_BITS = 6,
    parameter int LEN_BITS  = 10,
    parameter int DROP_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 alloc_req,
    output logic                 alloc_grant,
    output logic                 alloc_reject,
    output logic [NBUF_BITS-1:0] w_buf_id,
    input  logic                 wr_done,
    input  logic [LEN_BITS-1:0]  wr_len,
    output logic [8:0]           nreadouts_available,
    output logic [NBUF_BITS-1:0] r_buf_id,
    input  logic [NBUF_BITS-1:0] pick_buf_id,
    output logic [LEN_BITS-1:0]  buf_len,
    input  logic                 done_with_buffer,
    output logic [DROP_BITS-1:0] drop_count,
    input  logic                 err_clear,
    output logic [15:0]          status
);

    localparam int NBUF  = 1 << NBUF_BITS;
    localparam int OCC_W = NBUF_BITS + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1
    } state_t;

    // Sticky error bit positions inside err_reg
    localparam int ERR_REQ_BUSY = 0;
    localparam int ERR_SPURIOUS = 1;
    localparam int ERR_UNDERFLOW = 2;

    state_t               state_reg;
    logic [NBUF_BITS-1:0] wr_ptr_reg;
    logic [NBUF_BITS-1:0] r_buf_id_reg;
    logic [NBUF_BITS-1:0] w_buf_id_reg;
    logic [OCC_W-1:0]     committed_reg;
    logic [OCC_W-1:0]     committed_next;
    logic                 alloc_grant_reg;
    logic                 alloc_reject_reg;
    logic [DROP_BITS-1:0] drop_count_reg;
    logic [LEN_BITS-1:0]  buf_len_reg;
    logic [2:0]           err_reg;
    logic [2:0]           err_set;

    // Length table: never cleared, only overwritten by committed readouts
    logic [LEN_BITS-1:0]  length_table [NBUF];

    logic [OCC_W-1:0]     occupancy;
    logic                 full;
    logic                 is_busy;
    logic                 is_idle;
    logic                 commit_evt;
    logic                 release_evt;
    logic                 grant_evt;
    logic                 reject_evt;
    logic                 busy_req_evt;
    logic                 drop_sat;

    // Event decode from the current registered state
    always_comb begin
        is_busy      = (state_reg == ST_BUSY);
        is_idle      = (state_reg == ST_IDLE);
        occupancy    = committed_reg + OCC_W'(is_busy);
        // Full uses registered occupancy, so a same-cycle release cannot un-full a request
        full         = (occupancy == OCC_W'(NBUF));
        commit_evt   = enable && is_busy && wr_done;
        release_evt  = done_with_buffer && (committed_reg != '0);
        busy_req_evt = alloc_req && is_busy;
        grant_evt    = alloc_req && is_idle && !full;
        reject_evt   = busy_req_evt || (alloc_req && is_idle && full);
        drop_sat     = &drop_count_reg;

        err_set                = '0;
        err_set[ERR_REQ_BUSY]  = busy_req_evt;
        err_set[ERR_SPURIOUS]  = wr_done && is_idle;
        err_set[ERR_UNDERFLOW] = done_with_buffer && (committed_reg == '0);

        committed_next = committed_reg;
        case ({commit_evt, release_evt})
            2'b10:   committed_next = committed_reg + OCC_W'(1);
            2'b01:   committed_next = committed_reg - OCC_W'(1);
            default: committed_next = committed_reg;
        endcase
    end

    // Allocation FSM, pointers, counters and registered read port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            wr_ptr_reg       <= '0;
            r_buf_id_reg     <= '0;
            w_buf_id_reg     <= '0;
            committed_reg    <= '0;
            alloc_grant_reg  <= 1'b0;
            alloc_reject_reg <= 1'b0;
            drop_count_reg   <= '0;
            buf_len_reg      <= '0;
        end else if (!enable) begin
            // Flush abandons any in-flight buffer
            state_reg        <= ST_IDLE;
            wr_ptr_reg       <= '0;
            r_buf_id_reg     <= '0;
            w_buf_id_reg     <= '0;
            committed_reg    <= '0;
            alloc_grant_reg  <= 1'b0;
            alloc_reject_reg <= 1'b0;
            drop_count_reg   <= '0;
            buf_len_reg      <= '0;
        end else begin
            alloc_grant_reg  <= grant_evt;
            alloc_reject_reg <= reject_evt;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_evt) begin
                        w_buf_id_reg <= wr_ptr_reg;
                        wr_ptr_reg   <= wr_ptr_reg + NBUF_BITS'(1);
                        state_reg    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (wr_done) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
            if (reject_evt && !drop_sat) begin
                drop_count_reg <= drop_count_reg + DROP_BITS'(1);
            end
            if (release_evt) begin
                r_buf_id_reg <= r_buf_id_reg + NBUF_BITS'(1);
            end
            committed_reg <= committed_next;
            buf_len_reg   <= length_table[pick_buf_id];
        end
    end

    // Length table write port: the committed readout lands at the granted id
    always_ff @(posedge clk) begin
        if (commit_evt) begin
            length_table[w_buf_id_reg] <= wr_len;
        end
    end

    // Sticky error bits: a set event in the same cycle beats err_clear
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_err
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    err_reg[gi] <= 1'b0;
                end else if (!enable) begin
                    err_reg[gi] <= 1'b0;
                end else if (err_set[gi]) begin
                    err_reg[gi] <= 1'b1;
                end else if (err_clear) begin
                    err_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign alloc_grant         = alloc_grant_reg;
    assign alloc_reject        = alloc_reject_reg;
    assign w_buf_id            = w_buf_id_reg;
    assign r_buf_id            = r_buf_id_reg;
    assign nreadouts_available = 9'(committed_reg);
    assign buf_len             = buf_len_reg;
    assign drop_count          = drop_count_reg;
    assign status = {err_reg[ERR_UNDERFLOW], err_reg[ERR_SPURIOUS], err_reg[ERR_REQ_BUSY],
                     1'b0, state_reg, 3'b000, 7'(occupancy)};

endmodule

// File: tb/tb_daq_buffer_scheduler.sv
// Testbench for daq_buffer_scheduler: table of stimulus/expected records,
// expected records queued at drive time and compared after the clock edge.
module tb_daq_buffer_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        alloc_req;
    logic        alloc_grant;
    logic        alloc_reject;
    logic [5:0]  w_buf_id;
    logic        wr_done;
    logic [9:0]  wr_len;
    logic [8:0]  nreadouts_available;
    logic [5:0]  r_buf_id;
    logic [5:0]  pick_buf_id;
    logic [9:0]  buf_len;
    logic        done_with_buffer;
    logic [15:0] drop_count;
    logic        err_clear;
    logic [15:0] status;

    daq_buffer_scheduler #(
        .NBUF_BITS(6),
        .LEN_BITS (10),
        .DROP_BITS(16)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .alloc_req          (alloc_req),
        .alloc_grant        (alloc_grant),
        .alloc_reject       (alloc_reject),
        .w_buf_id           (w_buf_id),
        .wr_done            (wr_done),
        .wr_len             (wr_len),
        .nreadouts_available(nreadouts_available),
        .r_buf_id           (r_buf_id),
        .pick_buf_id        (pick_buf_id),
        .buf_len            (buf_len),
        .done_with_buffer   (done_with_buffer),
        .drop_count         (drop_count),
        .err_clear          (err_clear),
        .status             (status)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        en;
        logic        req;
        logic        done;
        logic [9:0]  len;
        logic        dwb;
        logic        clr;
        logic [5:0]  pick;
        logic        g;
        logic        rj;
        logic [5:0]  wb;
        logic [8:0]  nav;
        logic [5:0]  rb;
        logic        chk_bl;
        logic [9:0]  bl;
        logic [15:0] drop;
        logic [15:0] st;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic add(input string n, input int en, input int req, input int done,
                       input int len, input int dwb, input int clr, input int pick,
                       input int g, input int rj, input int wb, input int nav, input int rb,
                       input int chk, input int bl, input int drop, input int st);
        vec_t v;
        v.name = n;      v.en = 1'(en);    v.req = 1'(req);   v.done = 1'(done);
        v.len = 10'(len); v.dwb = 1'(dwb); v.clr = 1'(clr);   v.pick = 6'(pick);
        v.g = 1'(g);     v.rj = 1'(rj);    v.wb = 6'(wb);     v.nav = 9'(nav);
        v.rb = 6'(rb);   v.chk_bl = 1'(chk); v.bl = 10'(bl);  v.drop = 16'(drop);
        v.st = 16'(st);
        tbl.push_back(v);
    endtask

    task automatic cmp(input string vn, input string f, input logic [15:0] act,
                       input logic [15:0] req);
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s.%s: got %h, required %h", vn, f, act, req);
        end
    endtask

    task automatic check(input vec_t e);
        n_vec++;
        cmp(e.name, "alloc_grant",  16'(alloc_grant),         16'(e.g));
        cmp(e.name, "alloc_reject", 16'(alloc_reject),        16'(e.rj));
        cmp(e.name, "w_buf_id",     16'(w_buf_id),            16'(e.wb));
        cmp(e.name, "nreadouts",    16'(nreadouts_available), 16'(e.nav));
        cmp(e.name, "r_buf_id",     16'(r_buf_id),            16'(e.rb));
        cmp(e.name, "drop_count",   drop_count,               e.drop);
        cmp(e.name, "status",       status,                   e.st);
        if (e.chk_bl) cmp(e.name, "buf_len", 16'(buf_len), 16'(e.bl));
        $display("vec %0d %s: grant=%0d rej=%0d wb=%0d nav=%0d rb=%0d len=%h drop=%0d st=%h",
                 n_vec, e.name, alloc_grant, alloc_reject, w_buf_id, nav_int(),
                 r_buf_id, buf_len, drop_count, status);
    endtask

    function automatic int nav_int();
        return int'(nreadouts_available);
    endfunction

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        enable           = v.en;
        alloc_req        = v.req;
        wr_done          = v.done;
        wr_len           = v.len;
        done_with_buffer = v.dwb;
        err_clear        = v.clr;
        pick_buf_id      = v.pick;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(e);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; alloc_req = 1'b0; wr_done = 1'b0; wr_len = '0;
        done_with_buffer = 1'b0; err_clear = 1'b0; pick_buf_id = '0;

        // Name    en req done len  dwb clr pick g rj wb nav rb chk bl drop st
        add("a_req",   1,1,0,0,     0,0,0,  1,0,0, 0, 0, 0,0,     0,16'h0401);
        add("a_done",  1,0,1,'h123, 0,0,0,  0,0,0, 1, 0, 0,0,     0,16'h0001);
        add("a_read",  1,0,0,0,     0,0,0,  0,0,0, 1, 0, 1,'h123, 0,16'h0001);
        add("flush1",  0,0,0,0,     0,0,0,  0,0,0, 0, 0, 1,0,     0,16'h0000);
        // Fill all 64 buffers; each done also reads back the previous length
        for (int i = 0; i < 64; i++) begin
            add($sformatf("fill_req%0d", i),  1,1,0,0, 0,0,0, 1,0,i, i, 0, 0,0, 0, 16'h0400 | (i + 1));
            add($sformatf("fill_done%0d", i), 1,0,1,'h40 + i, 0,0,(i == 0) ? 0 : i - 1,
                0,0,i, i + 1, 0, 1,(i == 0) ? 'h123 : 'h40 + i - 1, 0, i + 1);
        end
        add("full_rej",  1,1,0,0,     0,0,0, 0,1,63, 64,0, 0,0,    1,16'h0040);
        add("release",   1,0,0,0,     1,0,0, 0,0,63, 63,1, 0,0,    1,16'h003F);
        add("wrap_gnt",  1,1,0,0,     0,0,0, 1,0,0,  63,1, 0,0,    1,16'h0440);
        add("busy_req",  1,1,0,0,     0,0,0, 0,1,0,  63,1, 0,0,    2,16'h2440);
        add("err_clr",   1,0,0,0,     0,1,0, 0,0,0,  63,1, 0,0,    2,16'h0440);
        add("wrap_done", 1,0,1,'h3FF, 0,0,0, 0,0,0,  64,1, 1,'h40, 2,16'h0040);
        add("full_rel",  1,1,0,0,     1,0,0, 0,1,0,  63,2, 0,0,    3,16'h003F);
        add("flush2",    0,0,0,0,     0,0,0, 0,0,0,  0, 0, 0,0,    0,16'h0000);
        for (int k = 0; k < 3; k++) begin
            add($sformatf("c_req%0d", k),  1,1,0,0, 0,0,0, 1,0,k, k, 0, 0,0, 0, 16'h0400 | (k + 1));
            add($sformatf("c_done%0d", k), 1,0,1,'h100 + k, 0,0,0, 0,0,k, k + 1, 0, 0,0, 0, k + 1);
        end
        add("c_req3",    1,1,0,0,    0,0,0, 1,0,3, 3,0, 0,0,    0,16'h0404);
        add("c_both",    1,0,1,'h55, 1,0,0, 0,0,3, 3,1, 0,0,    0,16'h0003);
        add("c_read",    1,0,0,0,    0,0,3, 0,0,3, 3,1, 1,'h55, 0,16'h0003);
        add("c_req4",    1,1,0,0,    0,0,0, 1,0,4, 3,1, 0,0,    0,16'h0404);
        add("c_done_req",1,1,1,'h66, 0,0,0, 0,1,4, 4,1, 0,0,    1,16'h2004);
        add("c_clr",     1,0,0,0,    0,1,0, 0,0,4, 4,1, 0,0,    1,16'h0004);
        add("flush3",    0,0,0,0,    0,0,0, 0,0,0, 0,0, 0,0,    0,16'h0000);
        add("d_under",   1,0,0,0,    1,0,0, 0,0,0, 0,0, 0,0,    0,16'h8000);
        add("d_spur",    1,0,1,'h11, 0,0,0, 0,0,0, 0,0, 0,0,    0,16'hC000);
        add("d_clr_set", 1,0,0,0,    1,1,0, 0,0,0, 0,0, 0,0,    0,16'h8000);
        add("d_clr",     1,0,0,0,    0,1,0, 0,0,0, 0,0, 0,0,    0,16'h0000);
        for (int k = 0; k < 5; k++) begin
            add($sformatf("e_req%0d", k),  1,1,0,0, 0,0,0, 1,0,k, k, 0, 0,0, 0, 16'h0400 | (k + 1));
            add($sformatf("e_done%0d", k), 1,0,1,'h200 + k, 0,0,0, 0,0,k, k + 1, 0, 0,0, 0, k + 1);
        end
        add("e_req5",    1,1,0,0,    0,0,0, 1,0,5, 5,0, 0,0,    0,16'h0406);
        add("e_flush",   0,0,0,0,    0,0,0, 0,0,0, 0,0, 0,0,    0,16'h0000);
        add("e_spur",    1,0,1,'h77, 0,0,0, 0,0,0, 0,0, 0,0,    0,16'h4000);
        add("e_req",     1,1,0,0,    0,0,0, 1,0,0, 0,0, 0,0,    0,16'h4401);
        add("e_read5",   1,0,0,0,    0,0,5, 0,0,0, 0,0, 1,'h45, 0,16'h4401);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++;
        cmp("reset", "alloc_grant", 16'(alloc_grant), 16'h0);
        cmp("reset", "w_buf_id",    16'(w_buf_id),    16'h0);
        cmp("reset", "nreadouts",   16'(nreadouts_available), 16'h0);
        cmp("reset", "buf_len",     16'(buf_len),     16'h0);
        cmp("reset", "status",      status,           16'h0);
        $display("vec %0d reset: nav=%0d st=%h", n_vec, nav_int(), status);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Asynchronous reset mid-allocation clears outputs without a clock edge
        @(negedge clk);
        alloc_req = 1'b0; wr_done = 1'b0; done_with_buffer = 1'b0; err_clear = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_vec++;
        cmp("async_rst", "status",   status,             16'h0);
        cmp("async_rst", "w_buf_id", 16'(w_buf_id),      16'h0);
        cmp("async_rst", "grant",    16'(alloc_grant),   16'h0);
        $display("vec %0d async_rst: st=%h wb=%0d", n_vec, status, w_buf_id);
        @(negedge clk);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
